// File: rtl/i2c_csr_bridge_pkg.sv
// i2c_csr_bridge_pkg: shared CSR-bus widths and bridge FSM state encoding
package i2c_csr_bridge_pkg;
  localparam int CSR_AW = 5;
  localparam int CSR_DW = 8;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } i2c_state_t;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: SCL/SDA synchroniser with SCL edge, START and STOP detection
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_sda,
  output logic o_start,
  output logic o_stop
);
  logic [1:0] r_scl_s, r_sda_s;
  logic r_scl_d, r_sda_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s <= 2'b11;
      r_sda_s <= 2'b11;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_s <= {r_scl_s[0], i_scl};
      r_sda_s <= {r_sda_s[0], i_sda};
      r_scl_d <= r_scl_s[1];
      r_sda_d <= r_sda_s[1];
    end
  end
  assign o_scl_rise = r_scl_s[1] & ~r_scl_d;
  assign o_scl_fall = ~r_scl_s[1] & r_scl_d;
  assign o_sda      = r_sda_s[1];
  assign o_start    = r_scl_s[1] & r_scl_d & r_sda_d & ~r_sda_s[1];
  assign o_stop     = r_scl_s[1] & r_scl_d & ~r_sda_d & r_sda_s[1];
endmodule

// File: rtl/i2c_csr_bridge.sv
// i2c_csr_bridge: I2C target that maps a register pointer and data bytes onto a CSR bus
module i2c_csr_bridge
  import i2c_csr_bridge_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h4a
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [CSR_AW-1:0] csr_a,
  output logic [CSR_DW-1:0] csr_di,
  output logic              csr_we,
  input  logic [CSR_DW-1:0] csr_do
);
  i2c_state_t r_state, w_next;
  logic w_rise, w_fall, w_sda, w_start, w_stop, w_b8, w_match;
  logic [CSR_DW-1:0] r_rx, r_tx, r_di, w_rx_next;
  logic [CSR_AW-1:0] r_ptr;
  logic [3:0] r_cnt;
  logic r_oe, r_we, r_ack, r_ld;
  i2c_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_sda      (w_sda),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );
  assign w_b8      = r_cnt == 4'd8;
  assign w_match   = r_rx[7:1] == I2C_ADDR;
  assign w_rx_next = {r_rx[6:0], w_sda};
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = ADDR;
    else if (w_stop) w_next = IDLE;
    else if (w_fall)
      case (r_state)
        ADDR:      w_next = w_b8 ? (w_match ? ADDR_ACK : WAIT) : ADDR;
        ADDR_ACK:  w_next = r_rx[0] ? RDATA : REG;
        REG:       w_next = w_b8 ? REG_ACK : REG;
        REG_ACK:   w_next = WDATA;
        WDATA:     w_next = w_b8 ? WDATA_ACK : WDATA;
        WDATA_ACK: w_next = WDATA;
        RDATA:     w_next = w_b8 ? RDATA_ACK : RDATA;
        RDATA_ACK: w_next = r_ack ? RDATA : WAIT;
        default:   w_next = r_state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oe  <= 1'b0;
      r_we  <= 1'b0;
      r_ptr <= '0;
      r_di  <= '0;
      r_rx  <= '0;
      r_tx  <= '0;
      r_cnt <= '0;
      r_ack <= 1'b0;
      r_ld  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start || w_stop) begin
        r_cnt <= '0;
        r_oe  <= 1'b0;
        r_ld  <= 1'b0;
      end else if (r_ld) begin
        r_tx <= csr_do;
        r_oe <= ~csr_do[7];
        r_ld <= 1'b0;
      end else if (w_rise) begin
        r_cnt <= (r_state inside {ADDR, REG, WDATA, RDATA}) ? r_cnt + 4'd1 : r_cnt;
        r_rx  <= (r_state inside {ADDR, REG, WDATA}) ? w_rx_next : r_rx;
        r_ack <= (r_state == RDATA_ACK) ? ~w_sda : r_ack;
        if (r_state == WDATA && r_cnt == 4'd7) begin
          r_we <= 1'b1;
          r_di <= w_rx_next;
        end
      end else if (w_fall) begin
        case (r_state)
          ADDR: if (w_b8) begin
            r_cnt <= '0;
            r_oe  <= w_match;
          end
          REG: if (w_b8) begin
            r_cnt <= '0;
            r_oe  <= 1'b1;
            r_ptr <= r_rx[CSR_AW-1:0];
          end
          WDATA: if (w_b8) begin
            r_cnt <= '0;
            r_oe  <= 1'b1;
          end
          ADDR_ACK: begin
            r_tx <= csr_do;
            r_oe <= r_rx[0] & ~csr_do[7];
          end
          REG_ACK: r_oe <= 1'b0;
          WDATA_ACK: begin
            r_oe  <= 1'b0;
            r_ptr <= r_ptr + 1'b1;
          end
          RDATA: if (w_b8) begin
            r_cnt <= '0;
            r_oe  <= 1'b0;
          end else begin
            r_tx <= {r_tx[6:0], 1'b0};
            r_oe <= ~r_tx[6];
          end
          RDATA_ACK: begin
            r_ptr <= r_ptr + 1'b1;
            r_ld  <= r_ack;
          end
          default: ;
        endcase
      end
    end
  end
  assign sda_oe = r_oe;
  assign csr_a  = r_ptr;
  assign csr_di = r_di;
  assign csr_we = r_we;
endmodule

// File: tb/tb_i2c_csr_bridge.sv
// tb_i2c_csr_bridge: bit-banged I2C master with a transaction-level CSR reference model
module tb_i2c_csr_bridge;
  localparam logic [6:0] ADDR = 7'h4a;
  logic clk, rst, scl_in, sda_in, sda_oe, csr_we, m_sda;
  logic [4:0] csr_a;
  logic [7:0] csr_di, csr_do;
  logic [7:0] csr_mem [32];
  logic [31:0] wr_valid = '0;
  logic [7:0] m_mem [32];
  logic [4:0] m_ptr;
  logic [7:0] bq[$];
  logic [7:0] rq[$];
  logic [12:0] exp_wq[$];
  logic [12:0] obs[$];
  logic prev_we;
  int n_chk = 0;
  int n_pass = 0;
  i2c_csr_bridge #(.I2C_ADDR(7'h4a)) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_in (scl_in),
    .sda_in (sda_in),
    .sda_oe (sda_oe),
    .csr_a  (csr_a),
    .csr_di (csr_di),
    .csr_we (csr_we),
    .csr_do (csr_do)
  );
  assign sda_in = m_sda & ~sda_oe;
  assign csr_do = wr_valid[csr_a] ? csr_mem[csr_a] : {3'b000, csr_a};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (csr_we) begin
    csr_mem[csr_a] <= csr_di;
    wr_valid[csr_a] <= 1'b1;
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask
  always @(negedge clk) if (!rst) begin
    if (csr_we) begin
      logic [12:0] e;
      chk("we_single_cycle", int'(prev_we), 0);
      chk("we_expected", int'(exp_wq.size() > 0), 1);
      if (exp_wq.size() > 0) begin
        e = exp_wq.pop_front();
        chk("we_addr", int'(csr_a), int'(e[12:8]));
        chk("we_data", int'(csr_di), int'(e[7:0]));
      end
      obs.push_back({csr_a, csr_di});
    end
    prev_we = csr_we;
  end
  task automatic sbit(input logic b, output logic r);
    #30 m_sda = b;
    #70 scl_in = 1'b1;
    #50 r = sda_in;
    #50 scl_in = 1'b0;
  endtask
  task automatic start_c;
    #30 m_sda = 1'b1;
    #70 scl_in = 1'b1;
    #100 m_sda = 1'b0;
    #100 scl_in = 1'b0;
  endtask
  task automatic stop_c;
    #30 m_sda = 1'b0;
    #70 scl_in = 1'b1;
    #100 m_sda = 1'b1;
    #100;
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) sbit(b[i], r);
    sbit(1'b1, r);
    ack = ~r;
  endtask
  task automatic rd_byte(output logic [7:0] d, input logic ack);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      sbit(1'b1, r);
      d = {d[6:0], r};
    end
    sbit(~ack, r);
  endtask
  task automatic do_write(input logic [7:0] a);
    logic hit, ack;
    hit = (a[7:1] == ADDR) && !a[0];
    wr_byte(a, ack);
    chk("addr_ack", int'(ack), int'(a[7:1] == ADDR));
    for (int i = 0; i < bq.size(); i++) begin
      if (hit && i > 0) begin
        exp_wq.push_back({m_ptr, bq[i]});
        m_mem[m_ptr] = bq[i];
      end
      wr_byte(bq[i], ack);
      chk("data_ack", int'(ack), int'(hit));
      if (hit) m_ptr = (i == 0) ? bq[i][4:0] : m_ptr + 5'd1;
    end
  endtask
  task automatic do_read(input int n);
    logic [7:0] d;
    logic ack;
    wr_byte(8'h95, ack);
    chk("raddr_ack", int'(ack), 1);
    for (int i = 0; i < n; i++) begin
      rd_byte(d, i < n - 1);
      rq.push_back(d);
      chk("rd_data", int'(d), int'(m_mem[m_ptr]));
      m_ptr = m_ptr + 5'd1;
    end
    repeat (4) @(negedge clk);
    chk("nack_release", int'(sda_oe), 0);
  endtask
  task automatic partial(input int k);
    logic r, b;
    for (int i = 0; i < k; i++) begin
      b = 1'($urandom_range(0, 1));
      sbit(b, r);
    end
  endtask
  task automatic end_checks;
    chk("ptr", int'(csr_a), int'(m_ptr));
    chk("wq_empty", exp_wq.size(), 0);
    exp_wq.delete();
  endtask
  initial begin
    int kind, n;
    logic [7:0] a;
    logic ack;
    scl_in = 1'b1;
    m_sda = 1'b1;
    rst = 1'b1;
    prev_we = 1'b0;
    m_ptr = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_oe", int'(sda_oe), 0);
    chk("rst_we", int'(csr_we), 0);
    chk("rst_a", int'(csr_a), 0);
    chk("rst_di", int'(csr_di), 0);
    bq = {8'h02, 8'h6b};
    obs.delete();
    start_c; do_write(8'h94); stop_c;
    end_checks;
    chk("t1_nwr", obs.size(), 1);
    chk("t1_a", int'(obs[0][12:8]), 'h02);
    chk("t1_d", int'(obs[0][7:0]), 'h6b);
    bq = {8'h1f, 8'h11, 8'h22};
    obs.delete();
    start_c; do_write(8'h94); stop_c;
    end_checks;
    chk("t2_w0", int'(obs[0]), 'h1f11);
    chk("t2_w1", int'(obs[1]), 'h0022);
    chk("t2_ptr", int'(csr_a), 'h01);
    bq = {8'h03};
    rq.delete();
    start_c; do_write(8'h94); start_c; do_read(2); stop_c;
    end_checks;
    chk("t3_b0", int'(rq[0]), 'h03);
    chk("t3_b1", int'(rq[1]), 'h04);
    bq = {8'h01, 8'h55};
    obs.delete();
    start_c; do_write(8'h96); stop_c;
    end_checks;
    chk("t4_nowe", obs.size(), 0);
    bq = {8'h07};
    obs.delete();
    start_c; do_write(8'h94); partial(4); stop_c;
    end_checks;
    chk("t5_nowe", obs.size(), 0);
    chk("t5_ptr", int'(csr_a), 'h07);
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 3);
      bq.delete();
      bq.push_back(8'($urandom));
      case (kind)
        0: begin
          n = $urandom_range(0, 3);
          a = 8'h94;
          if ($urandom_range(0, 3) == 0) begin
            do a = 8'($urandom); while (a[7:1] == ADDR);
          end
          repeat (n) bq.push_back(8'($urandom));
          start_c; do_write(a); stop_c;
        end
        1: begin
          start_c; do_read($urandom_range(1, 3)); stop_c;
        end
        2: begin
          start_c; do_write(8'h94); start_c; do_read($urandom_range(1, 3)); stop_c;
        end
        default: begin
          start_c; do_write(8'h94); partial($urandom_range(1, 6)); stop_c;
        end
      endcase
      end_checks;
    end
    bq = {8'h05, 8'h12};
    start_c; do_write(8'h94); stop_c;
    end_checks;
    bq = {8'h05};
    start_c; do_write(8'h94); start_c;
    wr_byte(8'h95, ack);
    chk("t6_addr_ack", int'(ack), 1);
    repeat (6) @(negedge clk);
    chk("t6_pre_oe", int'(sda_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_oe", int'(sda_oe), 0);
    chk("t6_ptr", int'(csr_a), 0);
    chk("t6_we", int'(csr_we), 0);
    rst = 1'b0;
    m_ptr = '0;
    exp_wq.delete();
    wr_byte(8'h94, ack);
    chk("t6_ignored", int'(ack), 0);
    stop_c;
    end_checks;
    bq = {8'h09, 8'h5a};
    start_c; do_write(8'h94); stop_c;
    end_checks;
    chk("t6_alive_ptr", int'(csr_a), 'h0a);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
